// File: rtl/match_merge.sv
// Two-lane match merger into one FWFT FIFO; drops words when full, saturating drop counter.
// Optional MATCH_MERGE_DEDUP_EN: equal words on both lanes in one cycle are stored once.
module match_merge #(
  parameter int DWIDTH       = 16,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DWIDTH-1:0]        in0_data,
  input  logic                     in0_valid,
  input  logic [DWIDTH-1:0]        in1_data,
  input  logic                     in1_valid,
  output logic [DWIDTH-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   level,
  output logic [31:0]              drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] THRESH_L = (AW+1)'(AFULL_THRESH);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr, wr_ptr_p1;
  logic [AW:0]       free, level_next;
  logic              dup, v0, v1, pop;
  logic [1:0]        n_req, n_wr, n_drop;
  logic [DWIDTH-1:0] first_word;
  logic [32:0]       drop_sum;

`ifdef MATCH_MERGE_DEDUP_EN
  assign dup = in0_valid && in1_valid && (in0_data == in1_data);
`else
  assign dup = 1'b0;
`endif

  always_comb begin
    v0         = in0_valid;
    v1         = in1_valid && !dup;
    n_req      = {1'b0, v0} + {1'b0, v1};
    // space comes only from the pre-edge occupancy; a same-cycle pop never helps
    free       = DEPTH_L - level;
    if (free >= (AW+1)'(2))
      n_wr = n_req;
    else if (free == (AW+1)'(1))
      n_wr = (n_req != 2'd0) ? 2'd1 : 2'd0;
    else
      n_wr = 2'd0;
    n_drop     = n_req - n_wr;
    first_word = v0 ? in0_data : in1_data;
    wr_ptr_p1  = wr_ptr + AW'(1);
    pop        = out_valid && out_ready;
    level_next = level + (AW+1)'(n_wr) - (AW+1)'(pop);
    drop_sum   = {1'b0, drop_cnt} + 33'(n_drop);
  end

  assign out_valid = (level != '0);
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      drop_cnt    <= '0;
      almost_full <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr + AW'(n_wr);
      rd_ptr      <= rd_ptr + AW'(pop);
      level       <= level_next;
      almost_full <= (level_next >= THRESH_L);
      drop_cnt    <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
    end
  end

  // storage carries no reset; writes are blocked during reset so reset-cycle inputs vanish
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (n_wr != 2'd0) mem[wr_ptr]    <= first_word;
      if (n_wr == 2'd2) mem[wr_ptr_p1] <= in1_data;
    end
  end

endmodule

// File: tb/tb_match_merge.sv
// Directed bench for match_merge: merge order, fill/drop, partial space, dedup, wrap, reset.
module tb_match_merge;

  localparam int DW = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in0_data, in1_data, out_data;
  logic          in0_valid, in1_valid, out_valid, out_ready, almost_full;
  logic [4:0]    level;
  logic [31:0]   drop_cnt;

  int total = 0;
  int bad   = 0;

  match_merge #(.DWIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_data(in0_data), .in0_valid(in0_valid),
    .in1_data(in1_data), .in1_valid(in1_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .almost_full(almost_full), .level(level), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in0_valid = 1'b0;
    in1_valid = 1'b0;
  endtask

  logic [DW-1:0] q[$];

  initial begin
    rst_n = 1'b0; out_ready = 1'b0;
    in0_data = '0; in1_data = '0; idle();
    tick(); tick();
    chk("rst_level", 32'(level), 0);
    chk("rst_vld", 32'(out_valid), 0);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_drop", drop_cnt, 0);

    // two words in one cycle, lane 0 first
    rst_n = 1'b1; out_ready = 1'b1;
    in0_data = 16'h0011; in1_data = 16'h0022; in0_valid = 1'b1; in1_valid = 1'b1;
    tick(); idle();
    chk("pair_vld", 32'(out_valid), 1);
    chk("pair_d0", 32'(out_data), 32'h0011);
    chk("pair_lvl2", 32'(level), 2);
    tick();
    chk("pair_d1", 32'(out_data), 32'h0022);
    tick();
    chk("pair_lvl0", 32'(level), 0);
    chk("pair_vld0", 32'(out_valid), 0);

    // fill with no consumer, then one overflow cycle
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in0_data = 16'h0100 + 16'(2*k); in1_data = 16'h0101 + 16'(2*k);
      in0_valid = 1'b1; in1_valid = 1'b1;
      tick();
      chk("fill_lvl", 32'(level), 32'(2*k+2));
      chk("fill_af", 32'(almost_full), (2*k+2 >= 12) ? 1 : 0);
    end
    chk("fill_drop0", drop_cnt, 0);
    in0_data = 16'h0DEAD; in1_data = 16'h0BEEF;
    tick(); idle();
    chk("ovf_drop", drop_cnt, 2);
    chk("ovf_lvl", 32'(level), 16);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_dat", 32'(out_data), 32'h0100 + 32'(i));
      tick();
    end
    chk("drain_lvl", 32'(level), 0);
    chk("drain_af", 32'(almost_full), 0);

    // one free slot with a concurrent pop: lane 1 still dropped
    out_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      in0_data = 16'h0200 + 16'(2*k); in1_data = 16'h0201 + 16'(2*k);
      in0_valid = 1'b1; in1_valid = 1'b1;
      tick();
    end
    in1_valid = 1'b0; in0_data = 16'h020E;
    tick();
    chk("p15_lvl", 32'(level), 15);
    in0_data = 16'h02F0; in1_data = 16'h02F1; in0_valid = 1'b1; in1_valid = 1'b1;
    out_ready = 1'b1;
    tick(); idle();
    chk("p15_lvl_keep", 32'(level), 15);
    chk("p15_drop", drop_cnt, 3);
    for (int i = 0; i < 8; i++) begin
      chk("p15_dat", 32'(out_data), 32'h0201 + 32'(i));
      tick();
    end
    chk("p7_lvl", 32'(level), 7);

    // reset mid-stream; the input in the reset cycle is neither stored nor counted
    rst_n = 1'b0; in0_data = 16'h0777; in0_valid = 1'b1; out_ready = 1'b0;
    tick();
    chk("mrst_lvl", 32'(level), 0);
    chk("mrst_drop", drop_cnt, 0);
    chk("mrst_vld", 32'(out_valid), 0);
    chk("mrst_af", 32'(almost_full), 0);
    rst_n = 1'b1; in0_data = 16'h0555; out_ready = 1'b1;
    tick(); idle();
    chk("post_vld", 32'(out_valid), 1);
    chk("post_dat", 32'(out_data), 32'h0555);
    chk("post_lvl", 32'(level), 1);
    tick();
    chk("post_lvl0", 32'(level), 0);

    // equal words on both lanes
    out_ready = 1'b0;
    in0_data = 16'h0ABC; in1_data = 16'h0ABC; in0_valid = 1'b1; in1_valid = 1'b1;
    tick(); idle();
`ifdef MATCH_MERGE_DEDUP_EN
    chk("dup_lvl", 32'(level), 1);
`else
    chk("dup_lvl", 32'(level), 2);
`endif
    chk("dup_dat", 32'(out_data), 32'h0ABC);
    chk("dup_drop", drop_cnt, 0);
    out_ready = 1'b1;
    tick(); tick();
    chk("dup_empty", 32'(level), 0);

    // alternating single lanes, random consumer, across several pointer wraps
    for (int i = 0; i < 40; i++) begin
      in0_valid = (i % 2 == 0);
      in1_valid = (i % 2 == 1);
      in0_data  = 16'h3000 + 16'(i);
      in1_data  = 16'h3000 + 16'(i);
      out_ready = (q.size() >= 12) ? 1'b1 : 1'($urandom_range(0, 1));
      if (out_ready && q.size() != 0) begin
        chk("wrap_dat", 32'(out_data), 32'(q[0]));
        void'(q.pop_front());
      end
      tick();
      q.push_back(16'h3000 + 16'(i));
    end
    idle(); out_ready = 1'b1;
    for (int n = 0; n < 64 && q.size() != 0; n++) begin
      chk("wrap_tail", 32'(out_data), 32'(q[0]));
      void'(q.pop_front());
      tick();
    end
    chk("wrap_left", 32'(q.size()), 0);
    chk("wrap_lvl", 32'(level), 0);
    chk("wrap_drop", drop_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/match_merge.md
MATCH_MERGE -- requirements
Module: match_merge

Interface
REQ-001 SHALL have parameter DWIDTH, default 16: width of each match word (hash-table address of a hit).
REQ-002 SHALL have parameter DEPTH, default 16: FIFO entries; power of two, at least 4.
REQ-003 SHALL have parameter AFULL_THRESH, default 12: occupancy at or above which almost_full asserts.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have ports in0_data / in0_valid, input, DWIDTH / 1: lane-0 match word and qualifier from the bitmap lookup stage; no backpressure.
REQ-007 SHALL have ports in1_data / in1_valid, input, DWIDTH / 1: lane-1 match word and qualifier; no backpressure.
REQ-008 SHALL have ports out_data / out_valid, output, DWIDTH / 1: merged single-lane match stream.
REQ-009 SHALL have port out_ready, input, 1: consumer accepts out_data when out_valid and out_ready are both high.
REQ-010 SHALL have port almost_full, output, 1: throttle hint to the upstream pattern feeder.
REQ-011 SHALL have port level, output, log2(DEPTH)+1: current FIFO occupancy.
REQ-012 SHALL have port drop_cnt, output, 32: count of match words discarded for lack of space.

Function
REQ-013 SHALL merge up to two words per cycle into one FIFO; in the same cycle, lane 0 is written before lane 1.
REQ-014 SHALL compute free = DEPTH - level from pre-edge occupancy; a pop in the same cycle does not add space for that cycle's writes.
REQ-015 SHALL, when both lanes are valid: free >= 2 writes both; free == 1 writes lane 0 and drops lane 1 (drop_cnt +1); free == 0 drops both (drop_cnt +2).
REQ-016 SHALL, when a single lane is valid: write it if free >= 1, else drop it (drop_cnt +1).
REQ-017 SHALL present the FIFO head first-word-fall-through: out_valid = (level != 0); out_data = the head entry.
REQ-018 SHALL pop one entry per cycle when out_valid and out_ready are both high; out_data SHALL hold stable while out_valid is high and out_ready is low.
REQ-019 SHALL have latency of one cycle: a word written at edge N is on out_data after edge N when the FIFO was empty.
REQ-020 SHALL update level as level + writes - pop each cycle; simultaneous push and pop on a full FIFO is legal.
REQ-021 SHALL wrap the read and write pointers modulo DEPTH; with two writes, the second write goes to (wr_ptr+1) mod DEPTH.
REQ-022 SHALL drive almost_full as a register, high when the post-edge level >= AFULL_THRESH.
REQ-023 SHALL saturate drop_cnt at 0xFFFFFFFF; it never wraps.
REQ-024 SHALL ignore in*_data when the corresponding in*_valid is low.

Reset
REQ-025 SHALL, while rst_n is low at a clock edge, clear the pointers, level, and drop_cnt to 0 and drive out_valid = 0 and almost_full = 0; FIFO contents are don't-care.
REQ-026 SHALL discard inputs presented in a reset cycle and SHALL not count them as drops.
REQ-027 SHALL, on reset mid-stream, lose all queued words; the first valid input after release is output one cycle later.

Configuration
REQ-028 SHALL, with macro MATCH_MERGE_DEDUP_EN defined and both lanes valid with in0_data == in1_data, write only the lane-0 word (one slot needed); the suppressed duplicate is not a drop.
REQ-029 SHALL, with MATCH_MERGE_DEDUP_EN undefined, write equal words on both lanes as two separate entries.

Verification
REQ-030 SHALL cover: reset, then in0=0x0011 and in1=0x0022 valid for one cycle, out_ready=1 -> out 0x0011 then 0x0022 on consecutive cycles; level returns to 0.
REQ-031 SHALL cover: out_ready=0, both lanes valid for 8 cycles with DEPTH=16 -> level=16, almost_full=1 from level 12, drop_cnt=0; one more dual-valid cycle -> drop_cnt=2.
REQ-032 SHALL cover: level=15, both lanes valid, out_ready=1 -> lane 0 written, lane 1 dropped, drop_cnt +1, level stays 15.
REQ-033 SHALL cover: both lanes 0x0ABC -> one entry if MATCH_MERGE_DEDUP_EN is defined, two entries otherwise.
REQ-034 SHALL cover: 40 alternating single-lane writes with random out_ready -> output order identical to input order across pointer wrap.
REQ-035 SHALL cover: rst_n low for one cycle with level=7 and drop_cnt=3 -> level=0, drop_cnt=0, out_valid=0 on the next cycle.
